// File: rtl/mac_pkg.sv
// Shared types and default widths for the multiply-accumulate back end.
package mac_pkg;

    typedef enum logic {
        ACCUM = 1'b0,
        HOLD  = 1'b1
    } mac_state_t;

    localparam int DEF_N     = 5;
    localparam int DEF_TERMS = 4;
    localparam int DEF_ACC_W = 12;

endpackage

// File: rtl/mac_sat_add.sv
// Signed W-bit adder for the accumulator.
// Build option MAC_SATURATE_EN: clamp each sum to the signed W-bit range; otherwise wrap modulo 2^W.
module mac_sat_add
    import mac_pkg::*;
#(
    parameter int W = DEF_ACC_W
) (
    input  logic signed [W-1:0] a,
    input  logic signed [W-1:0] b,
    output logic signed [W-1:0] sum
);

`ifdef MAC_SATURATE_EN
    localparam logic signed [W-1:0] SAT_MAX = {1'b0, {(W-1){1'b1}}};
    localparam logic signed [W-1:0] SAT_MIN = {1'b1, {(W-1){1'b0}}};

    logic [W:0] wide;

    // One guard bit: overflow shows up as the top two bits disagreeing.
    always_comb begin
        wide = {a[W-1], a} + {b[W-1], b};
        if (wide[W] != wide[W-1]) begin
            sum = wide[W] ? SAT_MIN : SAT_MAX;
        end else begin
            sum = wide[W-1:0];
        end
    end
`else
    assign sum = a + b;
`endif

endmodule

// File: rtl/mac_accumulator.sv
// Sums TERMS signed products per result over valid/ready handshakes on both sides.
// Build option MAC_SATURATE_EN selects clamped rather than wrapping accumulation.
module mac_accumulator
    import mac_pkg::*;
#(
    parameter int N     = DEF_N,
    parameter int TERMS = DEF_TERMS,
    parameter int ACC_W = DEF_ACC_W
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic signed [2*N-1:0]   product,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic signed [ACC_W-1:0] acc_out
);

    localparam int                CNT_W = $clog2(TERMS);
    localparam logic [CNT_W-1:0]  LAST  = CNT_W'(TERMS - 1);

    mac_state_t              state_q, state_d;
    logic signed [ACC_W-1:0] acc_q, acc_d;
    logic [CNT_W-1:0]        count_q, count_d;

    logic signed [ACC_W-1:0] prod_ext;
    logic signed [ACC_W-1:0] sum;

    assign prod_ext = ACC_W'(product);

    mac_sat_add #(
        .W (ACC_W)
    ) u_add (
        .a   (acc_q),
        .b   (prod_ext),
        .sum (sum)
    );

    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        count_d = count_q;
        case (state_q)
            ACCUM: begin
                if (in_valid) begin
                    acc_d = sum;
                    if (count_q == LAST) begin
                        count_d = '0;
                        state_d = HOLD;
                    end else begin
                        count_d = count_q + CNT_W'(1);
                    end
                end
            end
            HOLD: begin
                // Result stays frozen until the consumer takes it.
                if (out_ready) begin
                    acc_d   = '0;
                    state_d = ACCUM;
                end
            end
            default: state_d = ACCUM;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ACCUM;
            acc_q   <= '0;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            count_q <= count_d;
        end
    end

    assign in_ready  = (state_q == ACCUM);
    assign out_valid = (state_q == HOLD);
    assign acc_out   = acc_q;

endmodule

// File: tb/tb_mac_accumulator.sv
// Directed bench: a default-width instance and an ACC_W=10 instance fed the same product stream.
module tb_mac_accumulator;

`ifdef MAC_SATURATE_EN
    localparam bit SAT = 1'b1;
`else
    localparam bit SAT = 1'b0;
`endif

    logic               clk = 1'b0;
    logic               rst;
    logic               in_valid;
    logic               out_ready;
    logic signed [9:0]  product;
    logic               in_ready, out_valid;
    logic signed [11:0] acc_out;
    logic               in_ready10, out_valid10;
    logic signed [9:0]  acc_out10;

    int pass_cnt  = 0;
    int total_cnt = 0;

    always #5 clk = ~clk;

    mac_accumulator #(.N(5), .TERMS(4), .ACC_W(12)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .product   (product),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .acc_out   (acc_out)
    );

    mac_accumulator #(.N(5), .TERMS(4), .ACC_W(10)) dut10 (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready10),
        .product   (product),
        .out_valid (out_valid10),
        .out_ready (out_ready),
        .acc_out   (acc_out10)
    );

    typedef struct {
        logic iv;
        int   p;
        logic ordy;
        logic eir;
        logic eov;
        int   eacc;
        int   e10w;
        int   e10s;
    } vec_t;

    vec_t tbl[24];

    task automatic chk(input string name, input int act, input int exp);
        total_cnt++;
        if (act !== exp) begin
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end else begin
            pass_cnt++;
        end
    endtask

    task automatic step(input logic iv, input int p, input logic ordy, input logic r);
        in_valid  = iv;
        product   = 10'(p);
        out_ready = ordy;
        rst       = r;
        @(posedge clk);
        #1;
    endtask

    task automatic expect_out(input string tag, input logic eir, input logic eov,
                              input int eacc, input int eacc10);
        int a12, a10;
        a12 = acc_out;
        a10 = acc_out10;
        chk({tag, " in_ready"}, int'(in_ready), int'(eir));
        chk({tag, " out_valid"}, int'(out_valid), int'(eov));
        chk({tag, " acc_out"}, a12, eacc);
        chk({tag, " acc_out10"}, a10, eacc10);
        $display("%s: iv=%0b p=%0d ordy=%0b -> in_ready=%0b out_valid=%0b acc=%0d acc10=%0d",
                 tag, in_valid, product, out_ready, in_ready, out_valid, a12, a10);
    endtask

    initial begin
        tbl[0]  = '{1'b1,   10, 1'b0, 1'b1, 1'b0,   10,   10,   10};
        tbl[1]  = '{1'b1,   -3, 1'b0, 1'b1, 1'b0,    7,    7,    7};
        tbl[2]  = '{1'b1,    7, 1'b0, 1'b1, 1'b0,   14,   14,   14};
        tbl[3]  = '{1'b1,   20, 1'b0, 1'b0, 1'b1,   34,   34,   34};
        tbl[4]  = '{1'b1,   99, 1'b0, 1'b0, 1'b1,   34,   34,   34};
        tbl[5]  = '{1'b0,    0, 1'b1, 1'b1, 1'b0,    0,    0,    0};
        tbl[6]  = '{1'b1,  256, 1'b0, 1'b1, 1'b0,  256,  256,  256};
        tbl[7]  = '{1'b1,  256, 1'b0, 1'b1, 1'b0,  512, -512,  511};
        tbl[8]  = '{1'b1,  256, 1'b0, 1'b1, 1'b0,  768, -256,  511};
        tbl[9]  = '{1'b1,  256, 1'b0, 1'b0, 1'b1, 1024,    0,  511};
        tbl[10] = '{1'b0,    0, 1'b1, 1'b1, 1'b0,    0,    0,    0};
        tbl[11] = '{1'b1, -240, 1'b0, 1'b1, 1'b0, -240, -240, -240};
        tbl[12] = '{1'b1, -240, 1'b0, 1'b1, 1'b0, -480, -480, -480};
        tbl[13] = '{1'b1, -240, 1'b0, 1'b1, 1'b0, -720,  304, -512};
        tbl[14] = '{1'b1, -240, 1'b0, 1'b0, 1'b1, -960,   64, -512};
        tbl[15] = '{1'b0,    0, 1'b1, 1'b1, 1'b0,    0,    0,    0};
        tbl[16] = '{1'b1,    5, 1'b0, 1'b1, 1'b0,    5,    5,    5};
        tbl[17] = '{1'b0,   77, 1'b0, 1'b1, 1'b0,    5,    5,    5};
        tbl[18] = '{1'b0,   77, 1'b0, 1'b1, 1'b0,    5,    5,    5};
        tbl[19] = '{1'b1,    1, 1'b0, 1'b1, 1'b0,    6,    6,    6};
        tbl[20] = '{1'b1,    1, 1'b0, 1'b1, 1'b0,    7,    7,    7};
        tbl[21] = '{1'b0,   77, 1'b0, 1'b1, 1'b0,    7,    7,    7};
        tbl[22] = '{1'b1,    1, 1'b0, 1'b0, 1'b1,    8,    8,    8};
        tbl[23] = '{1'b0,    0, 1'b1, 1'b1, 1'b0,    0,    0,    0};

        // Reset with in_valid low.
        step(1'b0, 0, 1'b0, 1'b1);
        step(1'b0, 0, 1'b0, 1'b1);
        expect_out("reset", 1'b1, 1'b0, 0, 0);
        step(1'b0, 0, 1'b0, 1'b0);
        expect_out("post_reset_idle", 1'b1, 1'b0, 0, 0);

        for (int i = 0; i < 24; i++) begin
            step(tbl[i].iv, tbl[i].p, tbl[i].ordy, 1'b0);
            expect_out($sformatf("vec%0d", i), tbl[i].eir, tbl[i].eov, tbl[i].eacc,
                       SAT ? tbl[i].e10s : tbl[i].e10w);
        end

        // Long HOLD with a pending product that must not be consumed.
        for (int i = 1; i <= 4; i++) begin
            step(1'b1, i, 1'b0, 1'b0);
        end
        expect_out("hold_enter", 1'b0, 1'b1, 10, 10);
        for (int i = 0; i < 5; i++) begin
            step(1'b1, 99, 1'b0, 1'b0);
            expect_out($sformatf("hold_stall%0d", i), 1'b0, 1'b1, 10, 10);
        end
        step(1'b1, 99, 1'b1, 1'b0);
        expect_out("hold_release", 1'b1, 1'b0, 0, 0);
        step(1'b1, 99, 1'b0, 1'b0);
        expect_out("pending_accept", 1'b1, 1'b0, 99, 99);
        step(1'b1, 1, 1'b0, 1'b0);
        step(1'b1, 1, 1'b0, 1'b0);
        step(1'b1, 1, 1'b0, 1'b0);
        expect_out("pending_result", 1'b0, 1'b1, 102, 102);
        step(1'b0, 0, 1'b1, 1'b0);
        expect_out("pending_drain", 1'b1, 1'b0, 0, 0);

        // Reset after two of four accepts, with a handshake active on the same edge.
        step(1'b1, 3, 1'b0, 1'b0);
        step(1'b1, 4, 1'b0, 1'b0);
        expect_out("partial", 1'b1, 1'b0, 7, 7);
        step(1'b1, 5, 1'b0, 1'b1);
        expect_out("mid_reset", 1'b1, 1'b0, 0, 0);
        for (int i = 0; i < 3; i++) begin
            step(1'b1, 1, 1'b0, 1'b0);
        end
        expect_out("after_reset3", 1'b1, 1'b0, 3, 3);
        step(1'b1, 1, 1'b0, 1'b0);
        expect_out("after_reset4", 1'b0, 1'b1, 4, 4);

        // Reset while holding a result, with out_ready low.
        step(1'b0, 0, 1'b0, 1'b1);
        expect_out("hold_reset", 1'b1, 1'b0, 0, 0);
        step(1'b0, 0, 1'b0, 1'b0);
        expect_out("hold_reset_idle", 1'b1, 1'b0, 0, 0);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
